alarm_ringer: RTL and testbench

- Downstream consumer of the 12-hour clock's alarm_trigger level.
- Turns a trigger rising edge into a pulsed buzzer drive with snooze, stop and auto-timeout.
- Sits between the clock core and the buzzer/LED pins, in the same clk domain, with its own seconds prescaler.

---
 rtl/alarm_ringer.sv | 217 +++++++++++++++++++++
 tb/tb_alarm_ringer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_ringer.sv
`default_nettype none
// ============================================================================
// Module      : alarm_ringer
// Description : Converts the rising edge of a 12-hour clock's alarm_trigger
//               level into a pulsed buzzer drive. Supports snooze (limited
//               per alarm event), stop, disable and an automatic ring timeout.
//               Includes a private seconds prescaler running in the clk domain.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk           in   system clock, all logic on posedge
//   reset_n       in   asynchronous active-low reset
//   alarm_enable  in   level; 0 disarms and forces IDLE
//   alarm_trigger in   level from clock core; rising edge starts ringing
//   snooze_btn    in   single-cycle pulse, pre-debounced
//   stop_btn      in   single-cycle pulse, pre-debounced
//   buzzer        out  registered buzzer drive
//   ringing       out  registered; 1 while in RING
//   snoozing      out  registered; 1 while in SNOOZE
//   snooze_count  out  registered; snoozes used in the current alarm event
// ----------------------------------------------------------------------------
// Build option:
//   ALARM_ESCALATE_EN  when defined, the beep half-period in RING becomes
//                      BEEP_CYCLES >> snooze_count (never below 1 cycle), so
//                      every re-ring after a snooze beeps faster. When not
//                      defined the half-period is always BEEP_CYCLES.
// ============================================================================
module alarm_ringer #(
    parameter int CLOCK_FREQ       = 50000000,
    parameter int BEEP_CYCLES      = 12500000,
    parameter int SNOOZE_SEC       = 300,
    parameter int RING_TIMEOUT_SEC = 60,
    parameter int MAX_SNOOZES      = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       alarm_enable,
    input  logic       alarm_trigger,
    input  logic       snooze_btn,
    input  logic       stop_btn,
    output logic       buzzer,
    output logic       ringing,
    output logic       snoozing,
    output logic [3:0] snooze_count
);

    // ------------------------------------------------------------------------
    // Counter widths. Each is sized so the counter never wraps before its
    // terminal compare; a floor of 1 bit keeps degenerate parameters legal.
    // ------------------------------------------------------------------------
    localparam int PRESC_RAW = $clog2(CLOCK_FREQ);
    localparam int PW        = (PRESC_RAW < 1) ? 1 : PRESC_RAW;
    localparam int BW        = $clog2(BEEP_CYCLES + 1);
    localparam int SEC_MAX   = (SNOOZE_SEC > RING_TIMEOUT_SEC) ? SNOOZE_SEC
                                                               : RING_TIMEOUT_SEC;
    localparam int SW        = $clog2(SEC_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } state_t;

    state_t          state;
    logic            trig_q;
    logic [PW-1:0]   presc;
    logic [SW-1:0]   sec_cnt;
    logic [BW-1:0]   beep_cnt;

    logic            trig_edge;
    logic            sec_tick;
    logic            ring_timeout;
    logic            snooze_done;
    logic            snooze_ok;
    logic [BW-1:0]   half_period;
    logic            beep_tc;

    assign trig_edge = alarm_trigger & ~trig_q;
    assign sec_tick  = (presc == PW'(CLOCK_FREQ - 1));

    // Timeouts fire on the tick that would bring sec_cnt up to the limit, so
    // the state change lands exactly N seconds after entry.
    assign ring_timeout = sec_tick && (sec_cnt == SW'(RING_TIMEOUT_SEC - 1));
    assign snooze_done  = sec_tick && (sec_cnt == SW'(SNOOZE_SEC - 1));

    assign snooze_ok = (snooze_count < 4'(MAX_SNOOZES));

`ifdef ALARM_ESCALATE_EN
    logic [31:0] shifted_period;

    // Shorter half-period per snooze already taken; clamp at one cycle.
    assign shifted_period = 32'(BEEP_CYCLES) >> snooze_count;
    assign half_period    = (shifted_period == 32'd0) ? BW'(1)
                                                      : BW'(shifted_period);
`else
    assign half_period = BW'(BEEP_CYCLES);
`endif

    // ">=" rather than "==" keeps the toggle well-defined even if the
    // half-period ever shrinks below the current count.
    assign beep_tc = (beep_cnt >= (half_period - BW'(1)));

    // ------------------------------------------------------------------------
    // Single-process state machine with registered outputs.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            trig_q       <= 1'b0;
            presc        <= '0;
            sec_cnt      <= '0;
            beep_cnt     <= '0;
            buzzer       <= 1'b0;
            ringing      <= 1'b0;
            snoozing     <= 1'b0;
            snooze_count <= 4'd0;
        end else begin
            trig_q <= alarm_trigger;

            case (state)
                ST_IDLE: begin
                    presc    <= '0;
                    sec_cnt  <= '0;
                    beep_cnt <= '0;
                    buzzer   <= 1'b0;
                    ringing  <= 1'b0;
                    snoozing <= 1'b0;
                    if (trig_edge && alarm_enable) begin
                        state   <= ST_RING;
                        buzzer  <= 1'b1;
                        ringing <= 1'b1;
                    end
                end

                ST_RING: begin
                    if (!alarm_enable || stop_btn || ring_timeout) begin
                        // Any way out of RING back to IDLE ends the event.
                        state        <= ST_IDLE;
                        presc        <= '0;
                        sec_cnt      <= '0;
                        beep_cnt     <= '0;
                        buzzer       <= 1'b0;
                        ringing      <= 1'b0;
                        snoozing     <= 1'b0;
                        snooze_count <= 4'd0;
                    end else if (snooze_btn && snooze_ok) begin
                        state        <= ST_SNOOZE;
                        presc        <= '0;
                        sec_cnt      <= '0;
                        beep_cnt     <= '0;
                        buzzer       <= 1'b0;
                        ringing      <= 1'b0;
                        snoozing     <= 1'b1;
                        snooze_count <= snooze_count + 4'd1;
                    end else begin
                        // Stay ringing; trigger edges do not restart timeout.
                        if (sec_tick) begin
                            presc   <= '0;
                            sec_cnt <= sec_cnt + SW'(1);
                        end else begin
                            presc <= presc + PW'(1);
                        end
                        if (beep_tc) begin
                            beep_cnt <= '0;
                            buzzer   <= ~buzzer;
                        end else begin
                            beep_cnt <= beep_cnt + BW'(1);
                        end
                    end
                end

                ST_SNOOZE: begin
                    if (!alarm_enable || stop_btn) begin
                        state        <= ST_IDLE;
                        presc        <= '0;
                        sec_cnt      <= '0;
                        beep_cnt     <= '0;
                        buzzer       <= 1'b0;
                        ringing      <= 1'b0;
                        snoozing     <= 1'b0;
                        snooze_count <= 4'd0;
                    end else if (snooze_done) begin
                        // Re-ring with fresh beep and timeout counters; the
                        // snooze count carries over to limit further snoozes.
                        state    <= ST_RING;
                        presc    <= '0;
                        sec_cnt  <= '0;
                        beep_cnt <= '0;
                        buzzer   <= 1'b1;
                        ringing  <= 1'b1;
                        snoozing <= 1'b0;
                    end else begin
                        if (sec_tick) begin
                            presc   <= '0;
                            sec_cnt <= sec_cnt + SW'(1);
                        end else begin
                            presc <= presc + PW'(1);
                        end
                    end
                end

                default: begin
                    state        <= ST_IDLE;
                    presc        <= '0;
                    sec_cnt      <= '0;
                    beep_cnt     <= '0;
                    buzzer       <= 1'b0;
                    ringing      <= 1'b0;
                    snoozing     <= 1'b0;
                    snooze_count <= 4'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alarm_ringer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_ringer
// Description : Self-checking bench for alarm_ringer. Expected output words
//               {buzzer, ringing, snoozing, snooze_count} are queued as each
//               cycle of stimulus is driven and compared after the clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_ringer;

    localparam int CLOCK_FREQ       = 10;
    localparam int BEEP_CYCLES      = 2;
    localparam int SNOOZE_SEC       = 3;
    localparam int RING_TIMEOUT_SEC = 5;
    localparam int MAX_SNOOZES      = 2;

    localparam int RING_LEN   = CLOCK_FREQ * RING_TIMEOUT_SEC;  // 50 cycles
    localparam int SNOOZE_LEN = CLOCK_FREQ * SNOOZE_SEC;        // 30 cycles

    // Beep half-period seen during a ring with 0/1/2 snoozes already used.
    localparam int H0 = 2;
`ifdef ALARM_ESCALATE_EN
    localparam int H1 = 1;
    localparam int H2 = 1;
`else
    localparam int H1 = 2;
    localparam int H2 = 2;
`endif

    logic       clk;
    logic       reset_n;
    logic       alarm_enable;
    logic       alarm_trigger;
    logic       snooze_btn;
    logic       stop_btn;
    logic       buzzer;
    logic       ringing;
    logic       snoozing;
    logic [3:0] snooze_count;

    int vectors;
    int miscompares;

    string      tag_q[$];
    logic [6:0] exp_q[$];
    string      mon_tag;
    logic [6:0] mon_exp;

    alarm_ringer #(
        .CLOCK_FREQ      (CLOCK_FREQ),
        .BEEP_CYCLES     (BEEP_CYCLES),
        .SNOOZE_SEC      (SNOOZE_SEC),
        .RING_TIMEOUT_SEC(RING_TIMEOUT_SEC),
        .MAX_SNOOZES     (MAX_SNOOZES)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .alarm_enable (alarm_enable),
        .alarm_trigger(alarm_trigger),
        .snooze_btn   (snooze_btn),
        .stop_btn     (stop_btn),
        .buzzer       (buzzer),
        .ringing      (ringing),
        .snoozing     (snoozing),
        .snooze_count (snooze_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s @%0t: got bz/rg/sz/cnt=%b want %b", tag, $time, got, want);
        end
    endtask

    // Scoreboard consumer: one expected word per clock edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_tag = tag_q.pop_front();
            mon_exp = exp_q.pop_front();
            check(mon_tag, {buzzer, ringing, snoozing, snooze_count}, mon_exp);
        end
    end

    function automatic logic [6:0] idle_w();
        return 7'b000_0000;
    endfunction

    function automatic logic [6:0] snz_w(input logic [3:0] cnt);
        return {1'b0, 1'b0, 1'b1, cnt};
    endfunction

    // Buzzer is high for the first half-period after entry, then alternates.
    function automatic logic [6:0] ring_w(input int k, input int half, input logic [3:0] cnt);
        logic bz;
        bz = (((k / half) % 2) == 0);
        return {bz, 1'b1, 1'b0, cnt};
    endfunction

    // Called at a negedge with inputs already set: queue the word expected
    // after the coming posedge, then advance to the next negedge.
    task automatic step(input string tag, input logic [6:0] want);
        tag_q.push_back(tag);
        exp_q.push_back(want);
        @(negedge clk);
    endtask

    task automatic ring_span(input string tag, input int k0, input int n,
                             input logic [3:0] cnt, input int half);
        for (int k = k0; k < k0 + n; k++) step(tag, ring_w(k, half, cnt));
    endtask

    task automatic snz_span(input string tag, input int n, input logic [3:0] cnt);
        for (int i = 0; i < n; i++) step(tag, snz_w(cnt));
    endtask

    // From IDLE: produce a fresh rising edge; the ring entry is k=0.
    task automatic start_ring(input string tag);
        alarm_trigger = 1'b0;
        step({tag, "_pre"}, idle_w());
        alarm_trigger = 1'b1;
        ring_span({tag, "_entry"}, 0, 1, 4'd0, H0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors       = 0;
        miscompares   = 0;
        reset_n       = 1'b0;
        alarm_enable  = 1'b0;
        alarm_trigger = 1'b0;
        snooze_btn    = 1'b0;
        stop_btn      = 1'b0;
        @(negedge clk);

        // 1. Reset held with inputs toggling.
        for (int i = 0; i < 4; i++) begin
            alarm_enable  = i[0];
            alarm_trigger = ~i[0];
            snooze_btn    = i[1];
            stop_btn      = ~i[1];
            step("rst_held", idle_w());
        end
        snooze_btn    = 1'b0;
        stop_btn      = 1'b0;
        alarm_enable  = 1'b0;
        alarm_trigger = 1'b1;
        reset_n       = 1'b1;
        for (int i = 0; i < 4; i++) step("trig_disabled", idle_w());
        alarm_enable = 1'b1;       // level already high: no edge, no ring
        for (int i = 0; i < 3; i++) step("trig_level_only", idle_w());

        // 2. Ring and timeout; a trigger re-edge mid-ring must not restart it.
        start_ring("ring");
        ring_span("ring_beep", 1, 9, 4'd0, H0);
        alarm_trigger = 1'b0;
        ring_span("ring_beep", 10, 1, 4'd0, H0);
        alarm_trigger = 1'b1;
        ring_span("ring_beep", 11, RING_LEN - 11, 4'd0, H0);
        step("ring_timeout", idle_w());
        step("ring_after_to", idle_w());

        // 3. Snooze and re-ring; snooze_btn and trigger edges ignored in SNOOZE.
        start_ring("snz1");
        ring_span("snz1_ring", 1, 6, 4'd0, H0);
        snooze_btn = 1'b1;
        step("snz1_enter", snz_w(4'd1));
        snooze_btn = 1'b0;
        snz_span("snz1_wait", 4, 4'd1);
        snooze_btn = 1'b1;
        step("snz1_btn_ign", snz_w(4'd1));
        snooze_btn    = 1'b0;
        alarm_trigger = 1'b0;
        step("snz1_trig_lo", snz_w(4'd1));
        alarm_trigger = 1'b1;
        step("snz1_trig_ign", snz_w(4'd1));
        snz_span("snz1_wait", SNOOZE_LEN - 8, 4'd1);
        ring_span("reriing1", 0, 4, 4'd1, H1);

        // 4. Second snooze, then the limit: third press ignored, then timeout.
        snooze_btn = 1'b1;
        step("snz2_enter", snz_w(4'd2));
        snooze_btn = 1'b0;
        snz_span("snz2_wait", SNOOZE_LEN - 1, 4'd2);
        ring_span("rering2", 0, 5, 4'd2, H2);
        snooze_btn = 1'b1;
        ring_span("snz_limit", 5, 1, 4'd2, H2);
        snooze_btn = 1'b0;
        ring_span("rering2", 6, RING_LEN - 6, 4'd2, H2);
        step("limit_timeout", idle_w());

        // 5. Stop and snooze together in RING; stop / disable in SNOOZE.
        start_ring("coll");
        ring_span("coll_ring", 1, 2, 4'd0, H0);
        snooze_btn = 1'b1;
        step("coll_snz", snz_w(4'd1));
        snooze_btn = 1'b0;
        snz_span("coll_wait", SNOOZE_LEN - 1, 4'd1);
        ring_span("coll_rering", 0, 3, 4'd1, H1);
        stop_btn   = 1'b1;
        snooze_btn = 1'b1;
        step("stop_snz_same", idle_w());
        stop_btn   = 1'b0;
        snooze_btn = 1'b0;
        start_ring("sstop");
        snooze_btn = 1'b1;
        step("sstop_snz", snz_w(4'd1));
        snooze_btn = 1'b0;
        snz_span("sstop_wait", 3, 4'd1);
        stop_btn = 1'b1;
        step("stop_in_snooze", idle_w());
        stop_btn = 1'b0;
        start_ring("sdis");
        snooze_btn = 1'b1;
        step("sdis_snz", snz_w(4'd1));
        snooze_btn = 1'b0;
        alarm_enable = 1'b0;
        step("disable_in_snooze", idle_w());
        alarm_enable = 1'b1;

        // 6. Disable in RING, then async reset mid-SNOOZE.
        start_ring("rdis");
        ring_span("rdis_ring", 1, 2, 4'd0, H0);
        alarm_enable = 1'b0;
        step("disable_in_ring", idle_w());
        alarm_enable = 1'b1;
        start_ring("mrst");
        ring_span("mrst_ring", 1, 1, 4'd0, H0);
        snooze_btn = 1'b1;
        step("mrst_snz", snz_w(4'd1));
        snooze_btn = 1'b0;
        snz_span("mrst_wait", 5, 4'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", {buzzer, ringing, snoozing, snooze_count}, idle_w());
        @(negedge clk);
        step("rst_hold", idle_w());
        reset_n = 1'b1;
        start_ring("post_rst");
        ring_span("post_rst_ring", 1, 4, 4'd0, H0);
        stop_btn = 1'b1;
        step("post_rst_stop", idle_w());
        stop_btn = 1'b0;

        @(negedge clk);
        check("sb_drain", 7'(exp_q.size()), 7'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
